// File: rtl/fir_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fir_host_ctrl
// Brief    : Frame sequencer between a valid/ready sample stream, the fir
//            memory-mapped bus and a valid/ready result stream. Clears the
//            fir, loads one frame, starts it, polls busy, reads back and
//            streams every result.
// Revision : 1.0 - initial release
// ============================================================================
module fir_host_ctrl #(
    parameter int N_SAMPLES   = 36,
    parameter int DW          = 16,
    parameter int AW          = 16,
    parameter int ADDR_STRIDE = 4,
    parameter int BSY_TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [1:0]    fir_ctrl,
    output logic [DW-1:0] fir_din,
    output logic [AW-1:0] fir_addr,
    input  logic [DW-1:0] fir_dout,
    input  logic          fir_bsy,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int c_KW = $clog2(N_SAMPLES + 1);
    localparam int c_TW = (BSY_TIMEOUT > 1) ? $clog2(BSY_TIMEOUT) : 1;

    localparam logic [c_KW-1:0] c_K_FIRST   = c_KW'(1);
    localparam logic [c_KW-1:0] c_K_LAST    = c_KW'(N_SAMPLES);
    localparam logic [c_TW-1:0] c_T_LAST    = c_TW'(BSY_TIMEOUT - 1);
    localparam logic [1:0]      c_CMD_NOP   = 2'b00;
    localparam logic [1:0]      c_CMD_CLR   = 2'b10;
    localparam logic [1:0]      c_CMD_START = 2'b01;

    // The highest sample address must fit in the fir address bus.
    if ((longint'(N_SAMPLES) * longint'(ADDR_STRIDE)) >= (longint'(1) << AW)) begin : g_addr_range_check
        $error("fir_host_ctrl: N_SAMPLES*ADDR_STRIDE does not fit in AW bits");
    end

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CLR       = 4'd1,
        ST_CLR_GAP   = 4'd2,
        ST_LOAD      = 4'd3,
        ST_PARK      = 4'd4,
        ST_START     = 4'd5,
        ST_START_GAP = 4'd6,
        ST_POLL      = 4'd7,
        ST_RD_ADDR   = 4'd8,
        ST_RD_WAIT   = 4'd9,
        ST_RD_CAP    = 4'd10,
        ST_RD_OUT    = 4'd11,
        ST_DONE      = 4'd12
    } state_t;

    state_t          r_state;
    state_t          w_state;
    logic [c_KW-1:0] r_k;
    logic [c_KW-1:0] w_k;
    logic [DW-1:0]   r_s0;
    logic [DW-1:0]   w_s0;
    logic [c_TW-1:0] r_timer;
    logic [c_TW-1:0] w_timer;

    logic            w_s_ready;
    logic            w_m_valid;
    logic [DW-1:0]   w_m_data;
    logic [1:0]      w_fir_ctrl;
    logic [DW-1:0]   w_fir_din;
    logic [AW-1:0]   w_fir_addr;
    logic            w_done;
    logic            w_err;
    logic [AW-1:0]   w_k_addr;
    logic            w_hs;

    // Next state and next value of every registered output.
    always_comb begin
        w_state    = r_state;
        w_k        = r_k;
        w_s0       = r_s0;
        w_timer    = r_timer;
        w_s_ready  = s_ready;
        w_m_valid  = m_valid;
        w_m_data   = m_data;
        w_fir_ctrl = fir_ctrl;
        w_fir_din  = fir_din;
        w_fir_addr = fir_addr;
        w_done     = 1'b0;
        w_err      = err;
        w_k_addr   = AW'(r_k) * AW'(ADDR_STRIDE);
        w_hs       = s_valid & s_ready;

        case (r_state)
            ST_IDLE: begin
                w_s_ready  = 1'b0;
                w_fir_addr = '0;
                // The waiting sample is left for LOAD; only the clear starts here.
                if (s_valid) begin
                    w_fir_ctrl = c_CMD_CLR;
                    w_state    = ST_CLR;
                end
            end
            ST_CLR: begin
                w_fir_ctrl = c_CMD_NOP;
                w_state    = ST_CLR_GAP;
            end
            ST_CLR_GAP: begin
                w_k       = c_K_FIRST;
                w_s_ready = 1'b1;
                w_state   = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_hs) begin
                    w_fir_din  = s_data;
                    w_fir_addr = w_k_addr;
                    if (r_k == c_K_FIRST) begin
                        w_s0 = s_data;
                    end
                    if (r_k == c_K_LAST) begin
                        w_s_ready = 1'b0;
                        w_state   = ST_PARK;
                    end else begin
                        w_k = r_k + c_KW'(1);
                    end
                end else begin
                    w_fir_addr = '0;
                end
            end
            ST_PARK: begin
                w_fir_addr = '0;
                w_fir_din  = r_s0;
                w_state    = ST_START;
            end
            ST_START: begin
                w_fir_ctrl = c_CMD_START;
                w_state    = ST_START_GAP;
            end
            ST_START_GAP: begin
                w_fir_ctrl = c_CMD_NOP;
                w_timer    = '0;
                w_state    = ST_POLL;
            end
            ST_POLL: begin
                if (!fir_bsy) begin
                    w_k     = c_K_FIRST;
                    w_state = ST_RD_ADDR;
                end else if (r_timer == c_T_LAST) begin
                    w_err   = 1'b1;
                    w_state = ST_IDLE;
                end else begin
                    w_timer = r_timer + c_TW'(1);
                end
            end
            ST_RD_ADDR: begin
                w_fir_addr = w_k_addr;
                w_state    = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                w_state = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                w_m_data  = fir_dout;
                w_m_valid = 1'b1;
                w_state   = ST_RD_OUT;
            end
            ST_RD_OUT: begin
                if (m_ready) begin
                    w_m_valid = 1'b0;
                    if (r_k == c_K_LAST) begin
                        w_done     = 1'b1;
                        w_fir_addr = '0;
                        w_state    = ST_DONE;
                    end else begin
                        w_k     = r_k + c_KW'(1);
                        w_state = ST_RD_ADDR;
                    end
                end
            end
            ST_DONE: begin
                w_fir_addr = '0;
                w_state    = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // State, counters and all outputs registered on the rising edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_k      <= '0;
            r_s0     <= '0;
            r_timer  <= '0;
            s_ready  <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            fir_ctrl <= c_CMD_NOP;
            fir_din  <= '0;
            fir_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_k      <= w_k;
            r_s0     <= w_s0;
            r_timer  <= w_timer;
            s_ready  <= w_s_ready;
            m_valid  <= w_m_valid;
            m_data   <= w_m_data;
            fir_ctrl <= w_fir_ctrl;
            fir_din  <= w_fir_din;
            fir_addr <= w_fir_addr;
            busy     <= (w_state != ST_IDLE);
            done     <= w_done;
            err      <= w_err;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_host_ctrl
// Brief    : Self-checking bench for fir_host_ctrl with a behavioural fir
//            (y[k] = x[k] + 2*x[k-1]) and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_host_ctrl;

    localparam int N      = 36;
    localparam int DW     = 16;
    localparam int AW     = 16;
    localparam int STRIDE = 4;
    localparam int TMO    = 1024;
    localparam int NVEC   = 5;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          s_valid  = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data   = '0;
    logic          m_valid;
    logic          m_ready  = 1'b1;
    logic [DW-1:0] m_data;
    logic [1:0]    fir_ctrl;
    logic [DW-1:0] fir_din;
    logic [AW-1:0] fir_addr;
    logic [DW-1:0] fir_dout = '0;
    logic          fir_bsy  = 1'b0;
    logic          busy;
    logic          done;
    logic          err;

    fir_host_ctrl #(
        .N_SAMPLES   (N),
        .DW          (DW),
        .AW          (AW),
        .ADDR_STRIDE (STRIDE),
        .BSY_TIMEOUT (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .fir_ctrl (fir_ctrl),
        .fir_din  (fir_din),
        .fir_addr (fir_addr),
        .fir_dout (fir_dout),
        .fir_bsy  (fir_bsy),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural fir ----------------
    logic [DW-1:0] mem [1:N];
    logic [DW-1:0] res [1:N];
    bit            loading      = 1'b0;
    int            n_wr         = 0;
    int            wr_bad       = 0;
    int            frame_wr     = 0;
    int            frame_wr_bad = 0;
    int            bsy_left     = 0;
    int            bsy_delay    = 5;

    always @(negedge clk) begin
        int a;
        logic [DW-1:0] prev;
        if (fir_ctrl == 2'b10) begin
            for (int i = 1; i <= N; i++) mem[i] = '0;
            loading = 1'b1;
            n_wr    = 0;
            wr_bad  = 0;
        end else if (fir_ctrl == 2'b01) begin
            loading      = 1'b0;
            frame_wr     = n_wr;
            frame_wr_bad = wr_bad;
            for (int i = 1; i <= N; i++) begin
                prev   = (i > 1) ? mem[i-1] : '0;
                res[i] = mem[i] + (prev << 1);
            end
            bsy_left = bsy_delay;
            fir_bsy  = 1'b1;
        end else begin
            if (loading && fir_addr != '0) begin
                n_wr++;
                if (n_wr <= N && int'(fir_addr) == n_wr * STRIDE) mem[n_wr] = fir_din;
                else wr_bad++;
            end
            if (fir_bsy) begin
                if (bsy_left == 0) fir_bsy = 1'b0;
                else bsy_left--;
            end
        end
        a = int'(fir_addr);
        if (a % STRIDE == 0 && a / STRIDE >= 1 && a / STRIDE <= N) fir_dout = res[a / STRIDE];
        else fir_dout = 16'hDEAD;
    end

    // ---------------- sink, scoreboard and bus monitor ----------------
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] xs [0:N];
    logic [DW-1:0] hold_data = '0;
    logic [DW-1:0] frame_s0  = '0;
    logic [DW-1:0] p1_din = '0, p2_din = '0, e;
    logic [AW-1:0] p1_addr = '0, p2_addr = '0;
    int  res_idx = 0, bp_idx = 0, bp_len = 0, stall = 0;
    int  n_done = 0, n_start = 0, n_mv = 0;
    int  tdone = 0, t10 = 0, t01 = 0, terr = 0;
    bit  have_done = 1'b0, err_seen = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            m_ready  = 1'b1;
            stall    = 0;
            err_seen = 1'b0;
        end else begin
            if (done) begin
                n_done++;
                tdone     = cyc;
                have_done = 1'b1;
            end
            if (err && !err_seen) begin
                err_seen = 1'b1;
                terr     = cyc;
            end
            if (fir_ctrl == 2'b10) begin
                t10 = cyc;
                if (have_done) chk("clr_after_done_gap", 32'(t10 - tdone >= 2), 1);
            end
            if (fir_ctrl == 2'b01) begin
                n_start++;
                t01 = cyc;
                chk("park_addr", 32'(p1_addr), 0);
                chk("park_din", 32'(p1_din), 32'(frame_s0));
                chk("last_wr_addr", 32'(p2_addr), N * STRIDE);
            end
            if (m_valid) begin
                n_mv++;
                if (res_idx + 1 == bp_idx && stall < bp_len) begin
                    if (stall == 0) hold_data = m_data;
                    else chk("bp_hold_data", 32'(m_data), 32'(hold_data));
                    chk("bp_hold_addr", 32'(fir_addr), bp_idx * STRIDE);
                    stall++;
                    m_ready = 1'b0;
                end else begin
                    m_ready = 1'b1;
                    stall   = 0;
                    res_idx++;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_result: got 0x%0h, expected no result", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", 32'(m_data), 32'(e));
                    end
                end
            end
        end
        p2_addr = p1_addr;
        p2_din  = p1_din;
        p1_addr = fir_addr;
        p1_din  = fir_din;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_samples(input int n, input int base, input int step, input bit gaps);
        int  i     = 0;
        int  guard = 0;
        bit  tog   = 1'b0;
        bit  hs;
        while (i < n && guard < 2000) begin
            @(negedge clk);
            tog = ~tog;
            if (gaps && !tog) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = DW'(base + step * i);
            end
            hs = s_valid && s_ready;
            @(posedge clk);
            if (hs) begin
                xs[i+1] = s_data;
                if (i == 0) frame_s0 = s_data;
                i++;
            end
            guard++;
        end
        chk("samples_accepted", 32'(i), 32'(n));
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic push_expected();
        xs[0] = '0;
        for (int k = 1; k <= N; k++) exp_q.push_back(DW'(xs[k] + (xs[k-1] << 1)));
    endtask

    task automatic wait_frame(input int d0);
        int cnt = 0;
        while (n_done == d0 && !err && cnt < 5000) begin
            @(negedge clk);
            cnt++;
        end
        repeat (2) @(negedge clk);
        #1;
        chk("frame_end_seen", 32'(cnt < 5000), 1);
    endtask

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] step;
        logic        gaps;
        logic [31:0] bp_idx;
        logic [31:0] bp_len;
        logic [31:0] bsy;
        logic        b2b;
        logic        exp_err;
        logic [31:0] exp_results;
        logic [31:0] exp_done;
    } vec_t;

    vec_t tbl [NVEC];

    initial begin
        int d0, s0c, mv0;
        tbl[0] = '{32'h0001, 32'd1,  1'b0, 32'd0, 32'd0, 32'd5,       1'b0, 1'b0, 32'd36, 32'd1};
        tbl[1] = '{32'h8000, 32'd7,  1'b1, 32'd0, 32'd0, 32'd3,       1'b0, 1'b0, 32'd36, 32'd1};
        tbl[2] = '{32'h1234, 32'd13, 1'b0, 32'd3, 32'd7, 32'd8,       1'b0, 1'b0, 32'd36, 32'd1};
        tbl[3] = '{32'hFFF0, 32'd3,  1'b0, 32'd0, 32'd0, 32'd0,       1'b1, 1'b0, 32'd36, 32'd1};
        tbl[4] = '{32'h0005, 32'd5,  1'b0, 32'd0, 32'd0, 32'd1000000, 1'b0, 1'b1, 32'd0,  32'd0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_fir_ctrl", 32'(fir_ctrl), 0);
        chk("rst_fir_addr", 32'(fir_addr), 0);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b1;

        for (int v = 0; v < NVEC; v++) begin
            bsy_delay = int'(tbl[v].bsy);
            bp_idx    = int'(tbl[v].bp_idx);
            bp_len    = int'(tbl[v].bp_len);
            res_idx   = 0;
            d0        = n_done;
            s0c       = n_start;
            mv0       = n_mv;
            send_samples(N, int'(tbl[v].base), int'(tbl[v].step), tbl[v].gaps);
            if (!tbl[v].exp_err) push_expected();
            if (v + 1 < NVEC && tbl[v+1].b2b) begin
                s_valid = 1'b1;
                s_data  = DW'(tbl[v+1].base);
            end
            wait_frame(d0);
            chk("results_count", 32'(res_idx), tbl[v].exp_results);
            chk("done_pulses", 32'(n_done - d0), tbl[v].exp_done);
            chk("err_flag", 32'(err), 32'(tbl[v].exp_err));
            chk("write_count", 32'(frame_wr), N);
            chk("write_addr_order", 32'(frame_wr_bad), 0);
            chk("start_count", 32'(n_start - s0c), 1);
            chk("scoreboard_empty", 32'(exp_q.size()), 0);
            if (tbl[v].exp_err) begin
                chk("timeout_cycles", 32'(terr - t01), TMO + 1);
                chk("busy_after_err", 32'(busy), 0);
                chk("m_valid_in_timeout", 32'(n_mv - mv0), 0);
            end
        end

        // Reset in the middle of LOAD abandons the frame and clears err.
        res_idx   = 0;
        bp_idx    = 0;
        bsy_delay = 4;
        s0c       = n_start;
        send_samples(10, 32'h0100, 3, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_fir_ctrl", 32'(fir_ctrl), 0);
        chk("mid_rst_fir_addr", 32'(fir_addr), 0);
        chk("mid_rst_fir_din", 32'(fir_din), 0);
        chk("mid_rst_s_ready", 32'(s_ready), 0);
        chk("mid_rst_m_valid", 32'(m_valid), 0);
        chk("mid_rst_m_data", 32'(m_data), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_err", 32'(err), 0);
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'h4000;
        @(posedge clk);
        #1;
        chk("clr_after_rst", 32'(fir_ctrl), 2);
        chk("no_start_after_rst", 32'(n_start - s0c), 0);

        d0 = n_done;
        send_samples(N, 32'h4000, 32'h0111, 1'b0);
        push_expected();
        wait_frame(d0);
        chk("final_results_count", 32'(res_idx), N);
        chk("final_done_pulses", 32'(n_done - d0), 1);
        chk("final_err", 32'(err), 0);
        chk("final_write_count", 32'(frame_wr), N);
        chk("final_start_count", 32'(n_start - s0c), 1);
        chk("final_scoreboard_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
